// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the four-digit seven-segment scanner.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seven_seg_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low one-cold anode pattern for the given digit slot.
  function automatic logic [3:0] anode_on(digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// Bus between the BCD producer and the display scanner.
// LOAD is a one-cycle strobe with no back-pressure: BCDIN/DPIN are captured on every cycle LOAD is high.
interface seven_seg_scan_if;
  logic        LOAD;
  logic [15:0] BCDIN;
  logic [3:0]  DPIN;
  logic [6:0]  SEG;
  logic        DP;
  logic [3:0]  AN;
  logic        FRAME;

  modport master (output LOAD, BCDIN, DPIN, input SEG, DP, AN, FRAME);
  modport slave  (input LOAD, BCDIN, DPIN, output SEG, DP, AN, FRAME);
endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low seven-segment pattern.
// Non-decimal nibbles show a dash.
module bcd_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nibble)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed common-anode display driver with pending/display double buffer and anode guard.
// Define SEVEN_SEG_SCAN_BLANK_EN to blank leading zeros on the upper three digits.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
)(
  input  logic            CLK,
  input  logic            RST,
  seven_seg_scan_if.slave bus
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] cnt;
  digit_idx_t    idx;
  logic [15:0]   pend_bcd;
  logic [3:0]    pend_dp;
  logic          pend_flag;
  logic [15:0]   disp_bcd;
  logic [3:0]    disp_dp;

  logic [6:0]    seg_q;
  logic          dp_q;
  logic [3:0]    an_q;
  logic          frame_q;

  logic          last;
  logic          boundary;
  logic          in_guard;
  logic [3:0]    nib;
  logic [6:0]    dec_seg;
  logic [3:0]    blank;

  always_comb begin
    last     = (cnt == CW'(REFRESH_DIV - 1));
    boundary = last && (idx == 2'd3);
    in_guard = (cnt < CW'(GUARD));
    nib      = disp_bcd[{idx, 2'b00} +: 4];
  end

`ifdef SEVEN_SEG_SCAN_BLANK_EN
  // A digit blanks only when it and every digit to its left are zero; ones always shows.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = (disp_bcd[15:12] == 4'd0);
    blank[2] = blank[3] && (disp_bcd[11:8] == 4'd0);
    blank[1] = blank[2] && (disp_bcd[7:4] == 4'd0);
    blank[0] = 1'b0;
  end
`else
  assign blank = 4'b0000;
`endif

  bcd_to_seg u_dec (
    .nibble (nib),
    .seg    (dec_seg)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt       <= '0;
      idx       <= '0;
      pend_bcd  <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
      disp_bcd  <= '0;
      disp_dp   <= '0;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
      an_q      <= AN_OFF;
      frame_q   <= 1'b0;
    end else begin
      cnt     <= last ? '0 : cnt + CW'(1);
      if (last) idx <= idx + 2'd1;
      frame_q <= 1'b0;

      // A LOAD landing on the boundary bypasses pending so it is not held a whole extra frame.
      if (boundary) begin
        if (bus.LOAD) begin
          disp_bcd  <= bus.BCDIN;
          disp_dp   <= bus.DPIN;
          pend_flag <= 1'b0;
          frame_q   <= 1'b1;
        end else if (pend_flag) begin
          disp_bcd  <= pend_bcd;
          disp_dp   <= pend_dp;
          pend_flag <= 1'b0;
          frame_q   <= 1'b1;
        end
      end else if (bus.LOAD) begin
        pend_bcd  <= bus.BCDIN;
        pend_dp   <= bus.DPIN;
        pend_flag <= 1'b1;
      end

      if (in_guard) begin
        an_q  <= AN_OFF;
        seg_q <= SEG_BLANK;
        dp_q  <= 1'b1;
      end else begin
        an_q  <= anode_on(idx);
        seg_q <= blank[idx] ? SEG_BLANK : dec_seg;
        dp_q  <= ~disp_dp[idx];
      end
    end
  end

  assign bus.SEG   = seg_q;
  assign bus.DP    = dp_q;
  assign bus.AN    = an_q;
  assign bus.FRAME = frame_q;

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Four-digit multiplexed seven-segment display driver that consumes the packed 16-bit BCD word produced by the binary-to-BCD converter and scans it onto the board's common-anode display. It holds a pending/display double buffer so a new value never tears mid-frame. It also inserts an anode guard interval against ghosting and optionally blanks leading zeros. It is the last stage before the display pins.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); legal range 4..2^20.
- GUARD, 16: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- CLK  in  1  system clock (100 MHz).
- RST  in  1  reset; asynchronous, active-high.
- LOAD  in  1  one-cycle strobe: capture BCDIN/DPIN into the pending buffer.
- BCDIN  in  16  packed BCD; [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- DPIN  in  4  decimal-point enables, bit i for digit i, active-high.
- SEG  out  7  cathodes, active-low, {g,f,e,d,c,b,a}.
- DP  out  1  decimal-point cathode, active-low.
- AN  out  4  anodes, active-low; AN[0] = ones (rightmost).
- FRAME  out  1  one-cycle pulse when the display buffer is updated at the frame boundary.

## Operation
- Prescaler counts 0..REFRESH_DIV-1. The 2-bit digit index advances 0→1→2→3→0 on the last count.
- Slot i shows nibble BCDIN[4i+3:4i] from the display buffer on AN[i].
- During prescaler counts 0..GUARD-1: AN=4'hF, SEG=7'h7F, DP=1.
- Segment map (active-low):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10 (hex).
  - Nibbles A–F → 3F (dash).
- LOAD writes the pending buffer and sets the pending flag. A later LOAD before the frame boundary overwrites pending; last writer wins.
- Frame boundary is index 3 → 0 on the last prescaler count:
  - If pending is set, pending is copied to display, the flag is cleared, and FRAME pulses.
  - With no pending value: display is unchanged and there is no FRAME.
- LOAD on the boundary cycle: BCDIN/DPIN go directly into display, pending is cleared, and FRAME pulses.
- RST mid-frame aborts the scan immediately. Pending and display buffers are both cleared.

## Timing
- All outputs are registered.
- Reset values: AN=4'hF, SEG=7'h7F, DP=1, FRAME=0; prescaler, index, buffers and flag are all 0.
- After reset release the first slot is index 0. The guard applies, so the first lit output appears GUARD cycles plus one register stage later.
- Outputs reflect index/prescaler state with exactly 1 cycle of latency.
- Frame period is 4·REFRESH_DIV cycles.
- LOAD-to-visible latency is at most one frame plus GUARD+1 cycles.
- FRAME is asserted in the cycle after the boundary, together with the first guard cycle of slot 0.

## Configuration
- SEVEN_SEG_SCAN_BLANK_EN defined: leading-zero blanking is on.
  - Thousands, hundreds and tens are driven SEG=7'h7F when that nibble and every more-significant nibble are 0. The anode still pulses.
  - Ones is never blanked.
  - DP of a blanked digit still follows DPIN.
- Macro undefined: all four digits are always decoded.

## Structure
- Package seven_seg_pkg:
  - segment constants for 0–9, dash and blank;
  - digit-index typedef (2-bit);
  - anode-off and segment-off constants.
- Sub-module bcd_to_seg: combinational nibble → 7-bit active-low pattern using the package constants.
- All sequential logic lives in seven_seg_scan.

## Test plan
Bench runs with REFRESH_DIV=8, GUARD=2.
- Reset: assert RST mid-scan. AN=F, SEG=7F, DP=1, FRAME=0 are seen immediately (asynchronous) and held while RST=1.
- LOAD BCDIN=16'h1234, DPIN=4'b0100:
  - FRAME pulses at the next boundary.
  - Next frame shows AN=E/SEG=19, AN=D/SEG=30, AN=B/SEG=24 with DP=0, AN=7/SEG=79.
  - Each slot shows 2 guard cycles with AN=F.
- Two LOADs (16'h0005, then 16'h0987) in one frame: only 0987 is ever displayed, with exactly one FRAME.
- LOAD 16'h4321 exactly on the boundary cycle: displayed in the immediately following frame, pending flag clear, one FRAME.
- BCDIN=16'h0070:
  - With SEVEN_SEG_SCAN_BLANK_EN: digits 3 and 2 show 7F, digit 1 shows 78, digit 0 shows 40.
  - Without the macro: digits 3 and 2 show 40.
- BCDIN=16'hA00F: digits 3 and 0 show 3F (dash). No other output is affected.
